// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, stall/flush sequencing and EX-operand
// forwarding for the 5-stage MIPS pipeline. Stage valid bits, the action state
// and the debug counters are registered. All control and forwarding outputs are
// combinational from that registered state and the current stage inputs.
module pipeline_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs_addr,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wr_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_wr_addr,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_wr_addr,
    input  logic             branch_taken_mem,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [3:0]       stage_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // valid bits ordered {wb, mem, ex, id}
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic v_id, v_ex, v_mem, v_wb;
    logic ex_p, mem_p, wb_p;
    logic ex_hit, mem_hit, wb_hit;
    logic take, hazard, stall;

    assign {v_wb, v_mem, v_ex, v_id} = valid_q;

    // A producer only counts if its stage holds a real instruction writing a
    // non-zero register; $0 is hardwired and never creates a dependency.
    assign ex_p  = v_ex  & ex_reg_write  & (ex_wr_addr  != 5'd0);
    assign mem_p = v_mem & mem_reg_write & (mem_wr_addr != 5'd0);
    assign wb_p  = v_wb  & wb_reg_write  & (wb_wr_addr  != 5'd0);

    assign ex_hit  = (id_uses_rs & (id_rs_addr == ex_wr_addr))  | (id_uses_rt & (id_rt_addr == ex_wr_addr));
    assign mem_hit = (id_uses_rs & (id_rs_addr == mem_wr_addr)) | (id_uses_rt & (id_rt_addr == mem_wr_addr));
    assign wb_hit  = (id_uses_rs & (id_rs_addr == wb_wr_addr))  | (id_uses_rt & (id_rt_addr == wb_wr_addr));

    assign take = branch_taken_mem & v_mem;

    // With forwarding only a load in EX is too late to bypass; without it any
    // in-flight writer of a used source must drain past WB first.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) hazard = ex_p & ex_mem_read & ex_hit;
        else        hazard = (ex_p & ex_hit) | (mem_p & mem_hit) | (wb_p & wb_hit);
    end

    // A taken branch squashes everything younger, so it overrides any stall.
    assign stall = v_id & hazard & ~take;

    // Enable/flush outputs: flush on take, freeze front end and bubble EX on stall.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        if (take) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (stall) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end
    end

    // EX operand bypass select; the younger MEM result wins over WB.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (FWD_EN && v_ex) begin
            if (mem_p && (mem_wr_addr == ex_rs_addr))     fwd_a_sel = FWD_MEM;
            else if (wb_p && (wb_wr_addr == ex_rs_addr))  fwd_a_sel = FWD_WB;
            if (mem_p && (mem_wr_addr == ex_rt_addr))     fwd_b_sel = FWD_MEM;
            else if (wb_p && (wb_wr_addr == ex_rt_addr))  fwd_b_sel = FWD_WB;
        end
    end

    // Next valid bits, action state and counters. retire_cnt counts cycles in
    // which WB is occupied, including the cycle that starts at this edge, so it
    // stays in step with stage_valid[3].
    always_comb begin
        valid_d[0] = take ? 1'b0 : (stall ? v_id : 1'b1);
        valid_d[1] = (take | stall) ? 1'b0 : v_id;
        valid_d[2] = take ? 1'b0 : v_ex;
        valid_d[3] = v_mem;

        state_d = ST_RUN;
        if (take)       state_d = ST_FLUSH;
        else if (stall) state_d = ST_STALL;

        stall_cnt_d  = stall_cnt_q  + {{(CNT_W-1){1'b0}}, stall};
        flush_cnt_d  = flush_cnt_q  + {{(CNT_W-1){1'b0}}, take};
        retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, valid_d[3]};
    end

    // State registers with synchronous active-low reset; reset drops any pending hazard.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 4'b0000;
            state_q      <= ST_RUN;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stage_valid = valid_q;
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one instance with forwarding, one without,
// sharing stimulus. Expected combinational/registered outputs are queued per
// cycle and compared at the falling edge; counters are checked inline.
module tb_pipeline_hazard_ctrl;
    localparam logic [1:0] RUN = 2'b00, STL = 2'b01, FLS = 2'b10;
    localparam int NRM = 0, STAL = 1, TAKE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr;
    logic       id_uses_rs, id_uses_rt;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic [4:0] ex_wr_addr, mem_wr_addr, wb_wr_addr;
    logic       branch_taken_mem;

    logic        pc1, ifid1, fifid1, fidex1, fexmem1, pc0, ifid0, fifid0, fidex0, fexmem0;
    logic [1:0]  fa1, fb1, st1, fa0, fb0, st0;
    logic [3:0]  sv1, sv0;
    logic [31:0] stc1, flc1, rtc1, stc0, flc0, rtc0;

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_wr_addr(ex_wr_addr),
        .mem_reg_write(mem_reg_write), .mem_wr_addr(mem_wr_addr),
        .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr),
        .branch_taken_mem(branch_taken_mem),
        .pc_write_en(pc1), .if_id_write_en(ifid1),
        .if_id_flush(fifid1), .id_ex_flush(fidex1), .ex_mem_flush(fexmem1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stage_valid(sv1), .state(st1),
        .stall_cnt(stc1), .flush_cnt(flc1), .retire_cnt(rtc1)
    );

    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_wr_addr(ex_wr_addr),
        .mem_reg_write(mem_reg_write), .mem_wr_addr(mem_wr_addr),
        .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr),
        .branch_taken_mem(branch_taken_mem),
        .pc_write_en(pc0), .if_id_write_en(ifid0),
        .if_id_flush(fifid0), .id_ex_flush(fidex0), .ex_mem_flush(fexmem0),
        .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stage_valid(sv0), .state(st0),
        .stall_cnt(stc0), .flush_cnt(flc0), .retire_cnt(rtc0)
    );

    // {pc_we, ifid_we, if_id_flush, id_ex_flush, ex_mem_flush, fa, fb, valid, state}
    typedef struct {
        string       name;
        int          sel;
        logic [14:0] exp;
        logic [14:0] mask;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Scoreboard pop: everything queued for this cycle is compared mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [14:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = (e.sel == 1) ? {pc1, ifid1, fifid1, fidex1, fexmem1, fa1, fb1, sv1, st1}
                               : {pc0, ifid0, fifid0, fidex0, fexmem0, fa0, fb0, sv0, st0};
            total++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                bad++;
                $display("FAIL %s dut%0d: got %b want %b (pc,ifid,fl3,fa,fb,valid,state)",
                         e.name, e.sel, act, e.exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic push(input string nm, input int sel, input int kind,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] sv, input logic [1:0] st);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.mask = '1;
        case (kind)
            STAL:    e.exp = {5'b00010, fa, fb, sv, st};
            TAKE:    begin e.exp = {5'b10111, fa, fb, sv, st}; e.mask[13] = 1'b0; end
            default: e.exp = {5'b11000, fa, fb, sv, st};
        endcase
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs_addr = 5'd0; ex_rt_addr = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_wr_addr = 5'd0;
        mem_reg_write = 1'b0; mem_wr_addr = 5'd0;
        wb_reg_write = 1'b0; wb_wr_addr = 5'd0;
        branch_taken_mem = 1'b0;
    endtask

    function automatic logic [3:0] fill_sv(input int c);
        case (c)
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0011;
            3:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Reset both instances, then four idle cycles so every stage is valid.
    task automatic reset_fill(input string nm);
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            push(nm, 1, NRM, 2'b00, 2'b00, fill_sv(c), RUN);
            push(nm, 0, NRM, 2'b00, 2'b00, fill_sv(c), RUN);
            cyc();
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        cyc();
        cyc();
        total++;
        if ({sv1, st1, stc1, flc1, rtc1} !== {4'b0, RUN, 96'd0}) begin
            bad++;
            $display("FAIL reset_regs dut1: got v=%b s=%b %0d/%0d/%0d want 0000/00/0/0/0", sv1, st1, stc1, flc1, rtc1);
        end
        total++;
        if ({sv0, st0, stc0, flc0, rtc0} !== {4'b0, RUN, 96'd0}) begin
            bad++;
            $display("FAIL reset_regs dut0: got v=%b s=%b %0d/%0d/%0d want 0000/00/0/0/0", sv0, st0, stc0, flc0, rtc0);
        end
        reset = 1'b1;
        push("reset_out", 1, NRM, 2'b00, 2'b00, 4'b0000, RUN);
        push("reset_out", 0, NRM, 2'b00, 2'b00, 4'b0000, RUN);
        cyc();
    endtask

    // Ten unrelated ALU ops: producers everywhere, no matching sources.
    task automatic test_alu();
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs_addr = 5'd20; id_rt_addr = 5'd21;
            ex_rs_addr = 5'd20; ex_rt_addr = 5'd21;
            ex_reg_write = 1'b1;  ex_wr_addr  = 5'(c + 1);
            mem_reg_write = 1'b1; mem_wr_addr = 5'(c);
            wb_reg_write = 1'b1;  wb_wr_addr  = 5'(c + 2);
            push("alu", 1, NRM, 2'b00, 2'b00, fill_sv(c), RUN);
            push("alu", 0, NRM, 2'b00, 2'b00, fill_sv(c), RUN);
            cyc();
        end
        total++;
        if (rtc1 !== 32'd7 || stc1 !== 32'd0) begin
            bad++;
            $display("FAIL alu_cnt dut1: got retire=%0d stall=%0d want 7 0", rtc1, stc1);
        end
        total++;
        if (rtc0 !== 32'd7 || stc0 !== 32'd0) begin
            bad++;
            $display("FAIL alu_cnt dut0: got retire=%0d stall=%0d want 7 0", rtc0, stc0);
        end
    endtask

    // lw $2 ; add $3,$2,$4 with forwarding
    task automatic test_load_use();
        reset_fill("lu_fill");
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_wr_addr = 5'd2; ex_rs_addr = 5'd1;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs_addr = 5'd2; id_rt_addr = 5'd4;
        push("lu_stall", 1, STAL, 2'b00, 2'b00, 4'b1111, RUN);
        cyc();
        // bubble in EX still shows the load's fields: invalid stage, no stall, no bypass
        ex_rs_addr = 5'd2;
        mem_reg_write = 1'b1; mem_wr_addr = 5'd2;
        push("lu_bubble", 1, NRM, 2'b00, 2'b00, 4'b1101, STL);
        cyc();
        ex_rs_addr = 5'd2; ex_rt_addr = 5'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b0; ex_wr_addr = 5'd3;
        mem_reg_write = 1'b0; mem_wr_addr = 5'd0;
        wb_reg_write = 1'b1; wb_wr_addr = 5'd2;
        id_rs_addr = 5'd10; id_rt_addr = 5'd11;
        push("lu_fwd_wb", 1, NRM, 2'b10, 2'b00, 4'b1011, RUN);
        cyc();
        total++;
        if (stc1 !== 32'd1) begin
            bad++;
            $display("FAIL lu_stall_cnt dut1: got %0d want 1", stc1);
        end
    endtask

    // add $2 ; sub $5,$2,$2, then $0 and MEM-over-WB priority
    task automatic test_fwd_alu();
        reset_fill("fa_fill");
        ex_reg_write = 1'b1; ex_wr_addr = 5'd2; ex_rs_addr = 5'd7; ex_rt_addr = 5'd8;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs_addr = 5'd2; id_rt_addr = 5'd2;
        push("fa_nostall", 1, NRM, 2'b00, 2'b00, 4'b1111, RUN);
        cyc();
        idle();
        mem_reg_write = 1'b1; mem_wr_addr = 5'd2;
        ex_reg_write = 1'b1; ex_wr_addr = 5'd5; ex_rs_addr = 5'd2; ex_rt_addr = 5'd2;
        push("fa_mem", 1, NRM, 2'b01, 2'b01, 4'b1111, RUN);
        cyc();
        mem_wr_addr = 5'd0; wb_reg_write = 1'b1; wb_wr_addr = 5'd0;
        ex_rs_addr = 5'd0; ex_rt_addr = 5'd0;
        push("fa_r0", 1, NRM, 2'b00, 2'b00, 4'b1111, RUN);
        cyc();
        mem_wr_addr = 5'd9; wb_wr_addr = 5'd9; ex_rs_addr = 5'd9; ex_rt_addr = 5'd3;
        push("fa_prio", 1, NRM, 2'b01, 2'b00, 4'b1111, RUN);
        cyc();
        wb_wr_addr = 5'd12; ex_rs_addr = 5'd12; ex_rt_addr = 5'd9;
        push("fa_wb_mem", 1, NRM, 2'b10, 2'b01, 4'b1111, RUN);
        cyc();
        total++;
        if (stc1 !== 32'd0) begin
            bad++;
            $display("FAIL fa_stall_cnt dut1: got %0d want 0", stc1);
        end
    endtask

    // no forwarding: add $2 ; add $6,$2,$3 stalls until $2 leaves WB
    task automatic test_nofwd();
        reset_fill("nf_fill");
        ex_reg_write = 1'b1; ex_wr_addr = 5'd2;
        mem_reg_write = 1'b1; mem_wr_addr = 5'd7; ex_rs_addr = 5'd7;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs_addr = 5'd2; id_rt_addr = 5'd3;
        push("nf_s1", 0, STAL, 2'b00, 2'b00, 4'b1111, RUN);
        cyc();
        ex_reg_write = 1'b0; ex_rs_addr = 5'd0; mem_wr_addr = 5'd2;
        push("nf_s2", 0, STAL, 2'b00, 2'b00, 4'b1101, STL);
        cyc();
        mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_wr_addr = 5'd2;
        push("nf_s3", 0, STAL, 2'b00, 2'b00, 4'b1001, STL);
        cyc();
        wb_reg_write = 1'b0;
        push("nf_go", 0, NRM, 2'b00, 2'b00, 4'b0001, STL);
        cyc();
        total++;
        if (stc0 !== 32'd3 || st0 !== RUN || sv0 !== 4'b0011) begin
            bad++;
            $display("FAIL nf_after dut0: got stall=%0d state=%b valid=%b want 3 00 0011", stc0, st0, sv0);
        end
    endtask

    // taken branch in MEM coincides with a load-use hazard in ID
    task automatic test_branch();
        reset_fill("br_fill");
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_wr_addr = 5'd2; ex_rs_addr = 5'd1;
        id_uses_rs = 1'b1; id_rs_addr = 5'd2;
        branch_taken_mem = 1'b1;
        push("br_take", 1, TAKE, 2'b00, 2'b00, 4'b1111, RUN);
        cyc();
        total++;
        if (flc1 !== 32'd1 || stc1 !== 32'd0) begin
            bad++;
            $display("FAIL br_cnt dut1: got flush=%0d stall=%0d want 1 0", flc1, stc1);
        end
        push("br_after", 1, NRM, 2'b00, 2'b00, 4'b1000, FLS);
        cyc();
        push("br_refill", 1, NRM, 2'b00, 2'b00, 4'b0001, RUN);
        cyc();
        total++;
        if (flc1 !== 32'd1) begin
            bad++;
            $display("FAIL br_flush_cnt dut1: got %0d want 1", flc1);
        end
    endtask

    // reset arriving while the load-use stall is being taken
    task automatic test_reset_mid_stall();
        reset_fill("rs_fill");
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_wr_addr = 5'd2;
        id_uses_rs = 1'b1; id_rs_addr = 5'd2;
        reset = 1'b0;
        push("rs_stall", 1, STAL, 2'b00, 2'b00, 4'b1111, RUN);
        cyc();
        total++;
        if ({sv1, st1, stc1, flc1, rtc1} !== {4'b0, RUN, 96'd0}) begin
            bad++;
            $display("FAIL rs_regs dut1: got v=%b s=%b %0d/%0d/%0d want 0000/00/0/0/0", sv1, st1, stc1, flc1, rtc1);
        end
        reset = 1'b1;
        push("rs_out", 1, NRM, 2'b00, 2'b00, 4'b0000, RUN);
        cyc();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_alu();
        test_load_use();
        test_fwd_alu();
        test_nofwd();
        test_branch();
        test_reset_mid_stall();
        cyc();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
